ucode_sequencer: RTL and testbench

Multi-cycle control sequencer that sits directly upstream of the microcode ROM. Each cycle it produces the 5-bit instruction-class code and the 3-bit stage code that the ROM concatenates into its 8-bit row address. It decodes the fetched RV32I instruction into a class and steps through that class's stage sequence. It also tracks halts and retired instructions.

---
 rtl/ucode_pkg.sv | 25 ++
 rtl/inst_class_decoder.sv | 56 +++++
 rtl/ucode_sequencer.sv | 45 ++++
 tb/tb_ucode_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucode_pkg.sv
// ucode_pkg: stage/class codes, opcodes and stage-sequencing helpers for the microcode sequencer.
package ucode_pkg;
  localparam logic [2:0] STG_IF = 3'd0, STG_ID = 3'd1, STG_EX = 3'd2, STG_MEM = 3'd3, STG_WB = 3'd4;
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALTED} state_t;
  localparam logic [4:0]
    CLS_ADD = 5'd0, CLS_SUB = 5'd1, CLS_SLT = 5'd2, CLS_SLTU = 5'd3, CLS_XOR = 5'd4,
    CLS_OR = 5'd5, CLS_AND = 5'd6, CLS_SLL = 5'd7, CLS_SRL = 5'd8, CLS_SRA = 5'd9,
    CLS_ADDI = 5'd10, CLS_RSVD = 5'd11, CLS_SLTI = 5'd12, CLS_SLTIU = 5'd13, CLS_XORI = 5'd14,
    CLS_ORI = 5'd15, CLS_ANDI = 5'd16, CLS_SLLI = 5'd17, CLS_SRLI = 5'd18, CLS_SRAI = 5'd19,
    CLS_LOAD = 5'd20, CLS_STORE = 5'd21, CLS_JALR = 5'd22, CLS_JAL = 5'd23,
    CLS_BR = 5'd24, CLS_BRU = 5'd25, CLS_LUI = 5'd26, CLS_AUIPC = 5'd27, CLS_HALT = 5'd28;
  localparam logic [6:0]
    OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
    OP_BRANCH = 7'b1100011, OP_JALR = 7'b1100111, OP_JAL = 7'b1101111,
    OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  function automatic logic [2:0] final_stage(input logic [4:0] c);
    return c == CLS_STORE ? STG_MEM : (c == CLS_BR || c == CLS_BRU) ? STG_EX : STG_WB;
  endfunction
  // Successor of a non-final stage; lui/auipc skip straight past ID.
  function automatic logic [2:0] next_stage(input logic [2:0] s, input logic [4:0] c);
    return s == STG_IF ? (c == CLS_LUI ? STG_WB : c == CLS_AUIPC ? STG_EX : STG_ID) :
           s == STG_ID ? STG_EX :
           s == STG_EX ? ((c == CLS_LOAD || c == CLS_STORE) ? STG_MEM : STG_WB) : STG_WB;
  endfunction
endpackage

// File: rtl/inst_class_decoder.sv
// inst_class_decoder: combinational RV32I instruction to 5-bit microcode class.
module inst_class_decoder
  import ucode_pkg::*;
#(
  parameter int ILEN = 32
) (
  input  logic [ILEN-1:0] imem_data,
  output logic [4:0]      inst_class
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic       sh_ok;
  logic [4:0] r_cls, i_cls, b_cls;
  logic       unused_bits;
  assign op = imem_data[6:0];
  assign f3 = imem_data[14:12];
  assign f7 = imem_data[31:25];
  assign sh_ok = f7 == 7'h00 || f7 == 7'h20;
  assign unused_bits = ^imem_data;
  always_comb begin
    r_cls = CLS_HALT;
    if (f7 == 7'h00)
      case (f3)
        3'd0: r_cls = CLS_ADD;
        3'd1: r_cls = CLS_SLL;
        3'd2: r_cls = CLS_SLT;
        3'd3: r_cls = CLS_SLTU;
        3'd4: r_cls = CLS_XOR;
        3'd5: r_cls = CLS_SRL;
        3'd6: r_cls = CLS_OR;
        default: r_cls = CLS_AND;
      endcase
    else if (f7 == 7'h20)
      r_cls = f3 == 3'd0 ? CLS_SUB : f3 == 3'd5 ? CLS_SRA : CLS_HALT;
    case (f3)
      3'd0: i_cls = CLS_ADDI;
      3'd1: i_cls = sh_ok ? CLS_SLLI : CLS_HALT;
      3'd2: i_cls = CLS_SLTI;
      3'd3: i_cls = CLS_SLTIU;
      3'd4: i_cls = CLS_XORI;
      3'd5: i_cls = !sh_ok ? CLS_HALT : imem_data[30] ? CLS_SRAI : CLS_SRLI;
      3'd6: i_cls = CLS_ORI;
      default: i_cls = CLS_ANDI;
    endcase
    b_cls = f3[2:1] == 2'b01 ? CLS_HALT : f3[2:1] == 2'b11 ? CLS_BRU : CLS_BR;
    inst_class = op == OP_R      ? r_cls     :
                 op == OP_I      ? i_cls     :
                 op == OP_LOAD   ? CLS_LOAD  :
                 op == OP_STORE  ? CLS_STORE :
                 op == OP_BRANCH ? b_cls     :
                 op == OP_JALR   ? CLS_JALR  :
                 op == OP_JAL    ? CLS_JAL   :
                 op == OP_LUI    ? CLS_LUI   :
                 op == OP_AUIPC  ? CLS_AUIPC : CLS_HALT;
  end
endmodule

// File: rtl/ucode_sequencer.sv
// ucode_sequencer: steps each fetched instruction through its stage sequence and forms the microcode ROM address.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int ILEN   = 32,
  parameter int CWIDTH = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ILEN-1:0]   imem_data,
  input  logic              mem_ready,
  output logic [4:0]        inst_code,
  output logic [2:0]        stage,
  output logic [7:0]        ucode_addr,
  output logic              instr_done,
  output logic              halt,
  output logic [CWIDTH-1:0] instret
);
  state_t     state, nxt;
  logic [4:0] dec, code_q;
  inst_class_decoder #(.ILEN(ILEN)) u_dec (.imem_data(imem_data), .inst_class(dec));
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IF;
      code_q  <= '0;
      instret <= '0;
    end else begin
      state <= nxt;
      if (state == S_IF) code_q <= dec;
      if (instr_done) instret <= instret + CWIDTH'(1);
    end
  end
  // A MEM stall holds the stage; leaving the final stage always returns to IF.
  always_comb begin
    nxt = state == S_HALTED ? S_HALTED :
          state == S_IF ? (dec == CLS_HALT ? S_HALTED : state_t'(next_stage(STG_IF, dec))) :
          (state == S_MEM && !mem_ready) ? S_MEM :
          state == final_stage(code_q) ? S_IF : state_t'(next_stage(state, code_q));
    inst_code  = (RST || state == S_IF) ? dec : state == S_HALTED ? CLS_HALT : code_q;
    stage      = state == S_HALTED ? STG_IF : state;
    halt       = state == S_HALTED;
    instr_done = !RST && state == final_stage(code_q) && (state != S_MEM || mem_ready);
    ucode_addr = {inst_code, stage};
  end
endmodule

// File: tb/tb_ucode_sequencer.sv
// tb_ucode_sequencer: directed and randomized checks of the sequencer against a table-driven instruction model.
module tb_ucode_sequencer;
  typedef int q_t[$];
  localparam logic [31:0] I_ADD = 32'h003100B3, I_LW = 32'h0000A083, I_BEQ = 32'h00000063,
    I_BLTU = 32'h00006063, I_SW = 32'h0020A023, I_LUI = 32'h000010B7, I_AUIPC = 32'h00001097,
    I_SRAI = 32'h4010D093, I_BAD = 32'hFFFFFFFF;
  logic        CLK = 0, RST = 1, mem_ready = 0;
  logic [31:0] imem_data = 0;
  logic [4:0]  inst_code;
  logic [2:0]  stage;
  logic [7:0]  ucode_addr;
  logic        instr_done, halt;
  logic [31:0] instret;
  int          n_checks = 0, n_fail = 0;
  logic [31:0] exp_ret = 0;

  ucode_sequencer #(.ILEN(32), .CWIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .imem_data(imem_data), .mem_ready(mem_ready),
    .inst_code(inst_code), .stage(stage), .ucode_addr(ucode_addr),
    .instr_done(instr_done), .halt(halt), .instret(instret)
  );
  always #5 CLK = ~CLK;

  function automatic int ref_class(logic [31:0] x);
    int r_tab[16] = '{0, 7, 2, 3, 4, 8, 5, 6, 1, 28, 28, 28, 28, 9, 28, 28};
    int i_tab[8]  = '{10, 17, 12, 13, 14, 18, 15, 16};
    int b_tab[8]  = '{24, 24, 28, 28, 24, 24, 25, 25};
    logic [6:0] op = x[6:0];
    logic [6:0] f7 = x[31:25];
    logic [2:0] f3 = x[14:12];
    if (op == 7'h33) return (f7 == 7'h00 || f7 == 7'h20) ? r_tab[{f7[5], f3}] : 28;
    if (op == 7'h13) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin
        if (f7 != 7'h00 && f7 != 7'h20) return 28;
        if (f3 == 3'd5 && x[30]) return 19;
      end
      return i_tab[f3];
    end
    if (op == 7'h03) return 20;
    if (op == 7'h23) return 21;
    if (op == 7'h67) return 22;
    if (op == 7'h6F) return 23;
    if (op == 7'h63) return b_tab[f3];
    if (op == 7'h37) return 26;
    if (op == 7'h17) return 27;
    return 28;
  endfunction

  function automatic q_t ref_seq(int c);
    q_t q;
    if (c == 20) q = '{0, 1, 2, 3, 4};
    else if (c == 21) q = '{0, 1, 2, 3};
    else if (c == 24 || c == 25) q = '{0, 1, 2};
    else if (c == 26) q = '{0, 4};
    else if (c == 27) q = '{0, 2, 4};
    else q = '{0, 1, 2, 4};
    return q;
  endfunction

  function automatic logic [31:0] gen_valid();
    logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17};
    logic [31:0] x = $urandom;
    x[6:0] = ops[$urandom_range(0, 8)];
    if (x[6:0] == 7'h33) begin
      x[31:25] = x[30] ? 7'h20 : 7'h00;
      if (x[30]) x[14:12] = x[13] ? 3'd5 : 3'd0;
    end
    if (x[6:0] == 7'h13 && x[13:12] == 2'b01) x[31:25] = x[30] ? 7'h20 : 7'h00;
    if (x[6:0] == 7'h63 && x[14:13] == 2'b01) x[14] = 1'b1;
    return x;
  endfunction

  // Entered and left just after a falling edge; inputs are driven before the next rising edge.
  task automatic apply_reset();
    RST = 1;
    imem_data = $urandom;
    @(negedge CLK);
    RST = 0;
    exp_ret = 0;
  endtask

  task automatic drive_instr(input logic [31:0] ins, input int stalls, input string tag);
    int c = ref_class(ins);
    q_t seq = ref_seq(c);
    for (int k = 0; k < seq.size(); k++) begin
      int st = seq[k];
      int waits = st == 3 ? stalls : 0;
      for (int w = 0; w <= waits; w++) begin
        logic exp_done = (k == seq.size() - 1) && (w == waits);
        imem_data = k == 0 ? ins : $urandom;
        mem_ready = st == 3 ? (w == waits) : 1'($urandom_range(0, 1));
        #1;
        n_checks++;
        if ({stage, inst_code, ucode_addr, instr_done, halt} !== {st[2:0], c[4:0], c[4:0], st[2:0], exp_done, 1'b0}
            || instret !== exp_ret) begin
          n_fail++;
          $display("FAIL %s step%0d: stage=%0d code=%0d addr=%h done=%b halt=%b instret=%0d, want stage=%0d code=%0d done=%b halt=0 instret=%0d",
                   tag, k, stage, inst_code, ucode_addr, instr_done, halt, instret, st, c, exp_done, exp_ret);
        end
        @(negedge CLK);
      end
    end
    exp_ret++;
  endtask

  task automatic test_reset();
    RST = 1;
    imem_data = I_ADD;
    mem_ready = 1;
    #1;
    n_checks++;
    if (instr_done !== 1'b0 || inst_code !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_decode_add: done=%b code=%0d, want done=0 code=0", instr_done, inst_code);
    end
    @(negedge CLK);
    imem_data = I_LUI;
    #1;
    n_checks++;
    if (instr_done !== 1'b0 || inst_code !== 5'd26) begin
      n_fail++;
      $display("FAIL reset_decode_lui: done=%b code=%0d, want done=0 code=26", instr_done, inst_code);
    end
    @(negedge CLK);
    RST = 0;
    exp_ret = 0;
    imem_data = I_ADD;
    #1;
    n_checks++;
    if (stage !== 3'd0 || halt !== 1'b0 || instret !== 32'd0 || ucode_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: stage=%0d halt=%b instret=%0d addr=%h, want 0 0 0 00", stage, halt, instret, ucode_addr);
    end
  endtask

  task automatic test_add();
    apply_reset();
    drive_instr(I_ADD, 0, "add");
    #1;
    n_checks++;
    if (instret !== 32'd1) begin
      n_fail++;
      $display("FAIL add_instret: instret=%0d, want 1", instret);
    end
  endtask

  task automatic test_lw_stall();
    drive_instr(I_LW, 2, "lw_stall");
    drive_instr(I_LW, 0, "lw_nostall");
  endtask

  task automatic test_branch_store();
    drive_instr(I_BEQ, 0, "beq");
    drive_instr(I_BLTU, 0, "bltu");
    drive_instr(I_SW, 1, "sw");
  endtask

  task automatic test_upper();
    drive_instr(I_LUI, 0, "lui");
    drive_instr(I_AUIPC, 0, "auipc");
    drive_instr(I_SRAI, 0, "srai");
  endtask

  task automatic test_illegal();
    apply_reset();
    drive_instr(I_ADD, 0, "pre_halt_add");
    imem_data = I_BAD;
    mem_ready = 1;
    #1;
    n_checks++;
    if ({inst_code, stage, ucode_addr, halt, instr_done} !== {5'd28, 3'd0, 8'hE0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL illegal_if: code=%0d stage=%0d addr=%h halt=%b done=%b, want 28 0 e0 0 0",
               inst_code, stage, ucode_addr, halt, instr_done);
    end
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      imem_data = i < 2 ? I_ADD : $urandom;
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if ({inst_code, stage, ucode_addr, halt, instr_done} !== {5'd28, 3'd0, 8'hE0, 1'b1, 1'b0} || instret !== exp_ret) begin
        n_fail++;
        $display("FAIL halted%0d: code=%0d stage=%0d addr=%h halt=%b done=%b instret=%0d, want 28 0 e0 1 0 %0d",
                 i, inst_code, stage, ucode_addr, halt, instr_done, instret, exp_ret);
      end
      @(negedge CLK);
    end
    RST = 1;
    @(negedge CLK);
    RST = 0;
    exp_ret = 0;
    imem_data = I_ADD;
    #1;
    n_checks++;
    if (halt !== 1'b0 || stage !== 3'd0 || instret !== 32'd0 || inst_code !== 5'd0) begin
      n_fail++;
      $display("FAIL halt_cleared: halt=%b stage=%0d instret=%0d code=%0d, want 0 0 0 0", halt, stage, instret, inst_code);
    end
    drive_instr(I_ADD, 0, "post_halt_add");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive_instr(I_ADD, 0, "mid_add");
    for (int k = 0; k < 3; k++) begin
      imem_data = k == 0 ? I_SW : $urandom;
      mem_ready = 1;
      RST = k == 2;
      #1;
      n_checks++;
      if (stage !== 3'(k) || instr_done !== 1'b0) begin
        n_fail++;
        $display("FAIL sw_pre_reset%0d: stage=%0d done=%b, want stage=%0d done=0", k, stage, instr_done, k);
      end
      @(negedge CLK);
    end
    RST = 0;
    exp_ret = 0;
    imem_data = I_LW;
    #1;
    n_checks++;
    if (stage !== 3'd0 || instret !== 32'd0 || instr_done !== 1'b0 || halt !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_reset_in_ex: stage=%0d instret=%0d done=%b halt=%b, want 0 0 0 0", stage, instret, instr_done, halt);
    end
    drive_instr(I_ADD, 0, "after_ex_reset");
    for (int k = 0; k < 5; k++) begin
      imem_data = k == 0 ? I_LW : $urandom;
      mem_ready = k == 4;
      RST = k == 4;
      #1;
      n_checks++;
      if (stage !== 3'(k < 3 ? k : 3) || instr_done !== 1'b0) begin
        n_fail++;
        $display("FAIL lw_pre_reset%0d: stage=%0d done=%b, want stage=%0d done=0", k, stage, instr_done, k < 3 ? k : 3);
      end
      @(negedge CLK);
    end
    RST = 0;
    exp_ret = 0;
    imem_data = I_ADD;
    #1;
    n_checks++;
    if (stage !== 3'd0 || instret !== 32'd0 || instr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_reset_in_mem: stage=%0d instret=%0d done=%b, want 0 0 0", stage, instret, instr_done);
    end
    drive_instr(I_AUIPC, 0, "after_mem_reset");
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 60; i++) drive_instr(gen_valid(), $urandom_range(0, 3), "random");
    #1;
    n_checks++;
    if (instret !== exp_ret) begin
      n_fail++;
      $display("FAIL random_instret: instret=%0d, want %0d", instret, exp_ret);
    end
  endtask

  task automatic test_back_to_back();
    drive_instr(I_LUI, 0, "b2b_lui");
    drive_instr(I_LUI, 0, "b2b_lui2");
    drive_instr(I_BEQ, 0, "b2b_beq");
    drive_instr(I_SW, 0, "b2b_sw");
    drive_instr(I_LW, 3, "b2b_lw");
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_add();
    test_lw_stall();
    test_branch_store();
    test_upper();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
